alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Output stage directly downstream of the 64-bit ALU datapath units (logical right shifter and siblings).
- Captures each combinational ALU result with its destination tag and computes status flags (zero, negative, carry) at capture.
- Buffers results in a small FIFO with a valid/ready handshake, so a stalled writeback does not force the ALU to hold its operands.
- Decouples the combinational ALU path from the writeback/register-file port by one registered boundary.

Parameters:
- WIDTH, 64, result data width in bits.
- TAG_W, 5, destination-register tag width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  ALU result on in_result is valid this cycle.
- in_ready  output  1  buffer can accept a result this cycle.
- in_result  input  WIDTH  ALU result, e.g. the shifter Result bus.
- in_tag  input  TAG_W  destination tag accompanying the result.
- in_carry  input  1  carry/borrow from adder path; shift ops drive 0.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  writeback consumes head entry.
- out_result  output  WIDTH  head entry result.
- out_tag  output  TAG_W  head entry tag.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- out_carry  output  1  head entry stored carry.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at edge): count=0; rd/wr pointers=0; out_valid=0; in_ready=1; out_result/out_tag/flags=0. rst takes priority over all other inputs.
- Push: occurs when in_valid && in_ready. Stores {result, tag, zero=(in_result==0), neg=in_result[WIDTH-1], carry=in_carry} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). Derived from registered count only; no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_* present the entry at rd_ptr. All out_* data and flag outputs are 0 when count==0.
- Latency: a result pushed at edge N is visible on out_* after edge N; minimum one cycle. No same-cycle bypass from in to out.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop.
  - unchanged with neither.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored, even if a pop occurs the same cycle. in_ready reasserts the cycle after the pop.
- Empty (count==0): no pop possible. A push makes out_valid=1 next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap silently; count disambiguates full from empty.
- flush=1: next state is count=0 with pointers=0, same as reset for storage state. Flush overrides a push and a pop in the same cycle; the pushed result is discarded.
- Reset or flush mid-stream: all buffered entries are lost. in_ready=1 in the following cycle.
- Handshake ordering: strict FIFO; entries leave in push order. Tag and flags always travel with their own result.
- Upstream must hold in_* stable while in_valid && !in_ready (standard valid/ready). The block does not check this.

Test Plan:
1. Reset, then push result 0x8000_0000_0000_0001 with tag 3 and out_ready=1 -> next cycle out_valid=1, out_result=0x8000000000000001, out_tag=3, out_neg=1, out_zero=0; entry drains; count returns to 0.
2. out_ready=0, push 4 results (tags 1..4, values 0,5,6,7) -> count=4, in_ready=0; a 5th in_valid is ignored; release out_ready -> tags pop 1,2,3,4 in order; first pop shows out_zero=1.
3. At count=2, simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap past DEPTH, output order preserved (sequence check).
4. When full, assert in_valid and out_ready in the same cycle -> exactly one pop, no push, count=3; in_ready=1 the next cycle.
5. With 3 entries buffered, assert flush together with in_valid -> count=0, out_valid=0, out_* all 0 next cycle; the flushed-cycle input does not appear later.
6. Assert rst mid-stream with 2 entries buffered and in_carry=1 on the input -> all outputs at reset values next cycle; a subsequent push with in_carry=1 yields out_carry=1.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Result buffer between the ALU datapath and writeback: captures result, tag and
// status flags into a small FIFO so a stalled writeback never holds the ALU.
module alu_result_buffer #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic [AW:0]      count
);

    // Handshake: a transfer happens on a rising edge where valid && ready on that
    // side. Both ready and valid depend only on the registered count, so there is
    // no combinational path from out_ready to in_ready or from in_* to out_*.

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
        logic             carry;
    } entry_t;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    entry_t        head;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage needs no reset: an entry is only visible while count covers it.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= '{result: in_result,
                             tag:    in_tag,
                             zero:   (in_result == '0),
                             neg:    in_result[WIDTH-1],
                             carry:  in_carry};
        end
    end

    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign out_result = head.result;
    assign out_tag    = head.tag;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_carry  = head.carry;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_buffer;

    localparam int W = 64;
    localparam int T = 5;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_result = '0;
    logic [T-1:0]  in_tag = '0;
    logic          in_carry = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic [T-1:0]  out_tag;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic [2:0]    count;

    int n_cmp = 0;
    int n_bad = 0;

    // Each queue entry is {result, tag, carry}; flags are derived at check time.
    logic [W+T:0] exp_q[$];

    alu_result_buffer #(.WIDTH(W), .TAG_W(T), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_tag(in_tag), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
        .out_carry(out_carry), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [W-1:0] r;
        logic [T-1:0] t;
        logic         c;
        r = '0; t = '0; c = 1'b0;
        if (exp_q.size() != 0) begin
            {r, t, c} = exp_q[0];
        end
        chk("m_count", W'(count), W'(exp_q.size()));
        chk("m_in_ready", W'(in_ready), W'(exp_q.size() != D));
        chk("m_out_valid", W'(out_valid), W'(exp_q.size() != 0));
        chk("m_out_result", out_result, r);
        chk("m_out_tag", W'(out_tag), W'(t));
        chk("m_out_zero", W'(out_zero), W'((exp_q.size() != 0) && (r == 0)));
        chk("m_out_neg", W'(out_neg), W'(r[W-1]));
        chk("m_out_carry", W'(out_carry), W'(c));
    endtask

    // One clock: compare at negedge, advance model at posedge, return #1 later.
    task automatic cycle();
        logic         m_push;
        logic         m_pop;
        logic [W+T:0] ent;
        @(negedge clk);
        model_check();
        m_push = in_valid && (exp_q.size() != D);
        m_pop  = out_ready && (exp_q.size() != 0);
        ent    = {in_result, in_tag, in_carry};
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(ent);
        end
        #1;
    endtask

    task automatic push_one(input logic [W-1:0] r, input logic [T-1:0] t, input logic c);
        in_valid = 1'b1; in_result = r; in_tag = t; in_carry = c;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * D; i++) cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] vals [4];
        vals[0] = 64'd0; vals[1] = 64'd5; vals[2] = 64'd6; vals[3] = 64'd7;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_count", W'(count), 0);
        chk("reset_in_ready", W'(in_ready), 1);
        chk("reset_out_valid", W'(out_valid), 0);
        chk("reset_out_result", out_result, 0);

        // 1: single result with MSB set
        out_ready = 1'b1;
        push_one(64'h8000_0000_0000_0001, 5'd3, 1'b0);
        chk("t1_out_valid", W'(out_valid), 1);
        chk("t1_out_result", out_result, 64'h8000_0000_0000_0001);
        chk("t1_out_tag", W'(out_tag), 3);
        chk("t1_out_neg", W'(out_neg), 1);
        chk("t1_out_zero", W'(out_zero), 0);
        cycle();
        chk("t1_count_drained", W'(count), 0);
        out_ready = 1'b0;

        // 2: fill, ignored fifth push, ordered drain
        for (int i = 0; i < 4; i++) push_one(vals[i], T'(i + 1), 1'b0);
        chk("t2_count_full", W'(count), 4);
        chk("t2_in_ready_full", W'(in_ready), 0);
        push_one(64'hdead, 5'd9, 1'b1);
        chk("t2_count_ignored", W'(count), 4);
        out_ready = 1'b1;
        chk("t2_first_zero", W'(out_zero), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_tag", W'(out_tag), W'(i + 1));
            chk("t2_pop_result", out_result, vals[i]);
            cycle();
        end
        chk("t2_empty", W'(out_valid), 0);
        out_ready = 1'b0;

        // 3: steady push+pop at count 2, pointers wrap
        push_one(64'd100, 5'd10, 1'b0);
        push_one(64'd101, 5'd11, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_seq_tag", W'(out_tag), W'(10 + i));
            push_one(64'd102 + 64'(i), T'(12 + i), 1'b0);
            chk("t3_count", W'(count), 2);
        end
        drain();

        // 4: full with push and pop together
        for (int i = 0; i < 4; i++) push_one({$urandom, $urandom}, T'(i), 1'b1);
        in_valid = 1'b1; out_ready = 1'b1; in_tag = 5'd31;
        cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t4_count", W'(count), 3);
        chk("t4_in_ready", W'(in_ready), 1);

        // 5: flush with a concurrent push at 3 entries
        flush = 1'b1; in_valid = 1'b1; in_result = 64'h1234; in_tag = 5'd21;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_count", W'(count), 0);
        chk("t5_out_valid", W'(out_valid), 0);
        chk("t5_out_result", out_result, 0);
        chk("t5_out_tag", W'(out_tag), 0);
        push_one(64'h55, 5'd22, 1'b0);
        chk("t5_next_tag", W'(out_tag), 22);
        drain();

        // 6: reset mid-stream, then carry propagation
        push_one(64'h1, 5'd1, 1'b0);
        push_one(64'h2, 5'd2, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_carry = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_count", W'(count), 0);
        chk("t6_in_ready", W'(in_ready), 1);
        chk("t6_out_carry", W'(out_carry), 0);
        push_one(64'h7, 5'd7, 1'b1);
        chk("t6_carry_kept", W'(out_carry), 1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       in_result = '0;
                1:       in_result = {1'b1, 31'($urandom), 32'($urandom)};
                default: in_result = {$urandom, $urandom};
            endcase
            in_tag   = T'($urandom);
            in_carry = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
